// File: rtl/lcd_refresh_driver.sv
// HD44780-style 8-bit bus driver: runs the power-up init once, then rewrites both
// 16-character lines whenever the supplied row text differs from what is displayed.
module lcd_refresh_driver #(
  parameter int POWERUP_CYC = 200000,
  parameter int EN_CYC      = 10,
  parameter int CMD_CYC     = 500,
  parameter int CLR_CYC     = 20000
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic [127:0] row_1,
  input  logic [127:0] row_2,
  output logic         lcd_en,
  output logic         lcd_rw,
  output logic         lcd_rs,
  output logic [7:0]   lcd_data,
  output logic         busy,
  output logic         frame_done
);

  localparam int WAIT_MAX = (CMD_CYC > CLR_CYC) ? CMD_CYC : CLR_CYC;
  localparam int WR_MAX   = 1 + EN_CYC + WAIT_MAX;
  localparam int CNT_MAX  = (POWERUP_CYC > WR_MAX) ? POWERUP_CYC : WR_MAX;
  localparam int CW       = $clog2(CNT_MAX) + 1;

  // A write primitive ends on count EN_CYC + wait, giving 1 + EN_CYC + wait clocks.
  localparam logic [CW-1:0] PWR_LAST = CW'(POWERUP_CYC - 1);
  localparam logic [CW-1:0] EN_LAST  = CW'(EN_CYC);
  localparam logic [CW-1:0] CMD_LAST = CW'(EN_CYC + CMD_CYC);
  localparam logic [CW-1:0] CLR_LAST = CW'(EN_CYC + CLR_CYC);

  typedef enum logic [2:0] {
    PWR_WAIT, INIT, IDLE, L1_ADDR, L1_CHAR, L2_ADDR, L2_CHAR, DONE
  } state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [3:0]     idx, idx_n;
  logic [127:0]   snap_1, snap_1_n, snap_2, snap_2_n;
  logic           dirty, dirty_n;
  logic           wr_state, wr_state_n, wr_last;
  logic           en_n, rs_n, busy_n, done_n;
  logic [7:0]     data_n;
  logic [6:0]     char_hi;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state      <= PWR_WAIT;
      cnt        <= '0;
      idx        <= '0;
      snap_1     <= '0;
      snap_2     <= '0;
      dirty      <= 1'b1;
      lcd_en     <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_data   <= 8'h00;
      busy       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      snap_1     <= snap_1_n;
      snap_2     <= snap_2_n;
      dirty      <= dirty_n;
      lcd_en     <= en_n;
      lcd_rs     <= rs_n;
      lcd_data   <= data_n;
      busy       <= busy_n;
      frame_done <= done_n;
    end
  end

  // Bus outputs are decoded from the next state so they are registered yet aligned with it.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    snap_1_n = snap_1;
    snap_2_n = snap_2;
    dirty_n  = dirty;
    en_n     = 1'b0;
    rs_n     = 1'b0;
    data_n   = 8'h00;
    char_hi  = 7'd127;

    wr_state = (state == INIT) || (state == L1_ADDR) || (state == L1_CHAR) ||
               (state == L2_ADDR) || (state == L2_CHAR);
    wr_last  = (state == INIT && idx == 4'd3) ? (cnt == CLR_LAST) : (cnt == CMD_LAST);

    if (wr_state) begin
      cnt_n = wr_last ? '0 : cnt + 1'b1;
    end

    case (state)
      PWR_WAIT: begin
        if (cnt == PWR_LAST) begin
          state_n = INIT;
          cnt_n   = '0;
          idx_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      INIT: begin
        if (wr_last) begin
          if (idx == 4'd3) begin
            state_n = IDLE;
            idx_n   = '0;
            dirty_n = 1'b1;
          end else begin
            idx_n = idx + 4'd1;
          end
        end
      end
      IDLE: begin
        if (dirty || (row_1 != snap_1) || (row_2 != snap_2)) begin
          snap_1_n = row_1;
          snap_2_n = row_2;
          dirty_n  = 1'b0;
          state_n  = L1_ADDR;
          cnt_n    = '0;
          idx_n    = '0;
        end
      end
      L1_ADDR: begin
        if (wr_last) begin
          state_n = L1_CHAR;
          idx_n   = '0;
        end
      end
      L1_CHAR: begin
        if (wr_last) begin
          if (idx == 4'd15) begin
            state_n = L2_ADDR;
            idx_n   = '0;
          end else begin
            idx_n = idx + 4'd1;
          end
        end
      end
      L2_ADDR: begin
        if (wr_last) begin
          state_n = L2_CHAR;
          idx_n   = '0;
        end
      end
      L2_CHAR: begin
        if (wr_last) begin
          if (idx == 4'd15) begin
            state_n = DONE;
            idx_n   = '0;
          end else begin
            idx_n = idx + 4'd1;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = PWR_WAIT;
    endcase

    wr_state_n = (state_n == INIT) || (state_n == L1_ADDR) || (state_n == L1_CHAR) ||
                 (state_n == L2_ADDR) || (state_n == L2_CHAR);
    char_hi    = 7'd127 - {idx_n, 3'b000};

    case (state_n)
      INIT: begin
        case (idx_n)
          4'd0:    data_n = 8'h38;
          4'd1:    data_n = 8'h0C;
          4'd2:    data_n = 8'h06;
          default: data_n = 8'h01;
        endcase
      end
      L1_ADDR: data_n = 8'h80;
      L1_CHAR: begin
        rs_n   = 1'b1;
        data_n = snap_1_n[char_hi -: 8];
      end
      L2_ADDR: data_n = 8'hC0;
      L2_CHAR: begin
        rs_n   = 1'b1;
        data_n = snap_2_n[char_hi -: 8];
      end
      default: begin
        rs_n   = 1'b0;
        data_n = 8'h00;
      end
    endcase

    en_n   = wr_state_n && (cnt_n != '0) && (cnt_n <= EN_LAST);
    busy_n = !((state_n == IDLE) || (state_n == DONE));
    done_n = (state_n == DONE);
  end

  assign lcd_rw = 1'b0;

endmodule

// File: doc/lcd_refresh_driver.md
Name: lcd_refresh_driver

Overview:
- Downstream consumer of the 128-bit display rows (`play_row1/2`, `host_row1/2`) produced by the game top level.
- Converts a pair of 16-character ASCII rows into HD44780-style 8-bit parallel bus writes.
- Runs the power-up init sequence once, then rewrites both lines whenever the row contents change.
- One instance per physical LCD (player, host).

Parameters:
- POWERUP_CYC, 200000: clocks to wait after reset before the first command (≥15 ms at the target clock).
- EN_CYC, 10: clocks lcd_en is held high per write.
- CMD_CYC, 500: settle clocks after a normal command/data write, en low (≥40 us).
- CLR_CYC, 20000: settle clocks after the clear-display command (≥1.6 ms).

Ports:
- clk  input  1  system clock
- nRst  input  1  asynchronous active-low reset
- row_1  input  128  line 1 text; char 0 (leftmost) = row_1[127:120], char 15 = row_1[7:0]
- row_2  input  128  line 2 text, same packing
- lcd_en  output  1  LCD enable strobe
- lcd_rw  output  1  LCD read/write select; constant 0 (write only)
- lcd_rs  output  1  0 = command, 1 = data
- lcd_data  output  8  LCD data bus
- busy  output  1  high during init or a frame rewrite
- frame_done  output  1  one-cycle pulse after the last char of line 2 settles

Behaviour:
- Clock and reset: single clock domain. nRst is asynchronous, active-low.
- Reset values: lcd_en=0, lcd_rw=0, lcd_rs=0, lcd_data=8'h00, busy=1, frame_done=0, both snapshot registers=0, dirty flag=1.
  - Reset asserted mid-write aborts immediately; the sequence restarts from PWR_WAIT.
- Write primitive (every command/char): exactly 1 + EN_CYC + wait clocks, wait = CMD_CYC or CLR_CYC.
  - Clock 0: lcd_rs/lcd_data driven, en=0.
  - Clocks 1..EN_CYC: en=1.
  - Remaining clocks: en=0.
  - rs/data are held stable for the whole primitive.
- Top FSM states:
  - PWR_WAIT: count POWERUP_CYC, then go to INIT.
  - INIT: commands 8'h38 (8-bit, 2-line), 8'h0C (display on, cursor off), 8'h06 (increment, no shift), 8'h01 (clear; CLR_CYC wait). Then go to IDLE with dirty=1.
  - IDLE: busy=0. If dirty, or row_1/row_2 differ from the snapshots: load snapshots from the inputs, clear dirty, go to L1_ADDR.
  - L1_ADDR: command 8'h80, then L1_CHAR.
  - L1_CHAR: 16 data writes (rs=1) from snapshot line 1, chars 0..15, then L2_ADDR.
  - L2_ADDR: command 8'hC0, then L2_CHAR.
  - L2_CHAR: 16 data writes from snapshot line 2, then DONE.
  - DONE: frame_done=1 for one clock, return to IDLE.
- busy=1 in every state except IDLE and DONE.
- Frame content: the snapshot is taken only in IDLE. Input changes during a frame do not alter the frame in progress; the snapshot compare in IDLE triggers a new frame after DONE.
- Simultaneous change on the same clock IDLE evaluates: the current input values are captured.
- Character index: 4-bit counter; terminal value 15 is the transition condition, with no wrap into the next line.
- Counters: sized $clog2 of the largest parameter + 1. No overflow is permitted for any legal parameter value.
- Invalid/non-ASCII bytes are passed through unmodified.

Test Plan:
All scenarios use POWERUP_CYC=20, EN_CYC=2, CMD_CYC=4, CLR_CYC=10. Each write is 7 clocks; clear is 13 clocks.
- Reset then idle inputs:
  - No en pulse for 20 clocks after nRst rises.
  - Bus shows 38,0C,06,01 with rs=0, each en high exactly 2 clocks.
  - busy falls 54 clocks after reset release.
- row_1="HANGMAN GAME    ", row_2=all 8'h5F:
  - First frame shows 80 then H,A,N,G,... (rs=1), then C0, then sixteen 5F.
  - frame_done pulses 238 clocks after the frame starts.
- Hold rows constant after the first frame: no en pulses, busy=0, no further frame_done.
- Change row_2[7:0] to 8'h41 at the midpoint of the L1_CHAR writes:
  - The current frame still writes the old value at char 15.
  - A second frame starts immediately after DONE and writes 41 as the last char.
- Assert nRst during L2_CHAR char 5 with en high:
  - en=0 and data=00 asynchronously.
  - After release, the full init sequence repeats, then the full frame.
- Monitor lcd_rw for the entire run: never 1. Check rs/data never change while en=1.
